mbist_mbisr_ctrl: RTL

Parametrised March C- memory BIST engine with built-in self-repair logging, successor to the fixed-size MBIST/MBISR top. Drives one single-port SRAM through a synchronous test port, compares read data, and records up to SPARES distinct failing addresses in a remap CAM. After test, a functional-mode lookup steers faulty addresses to spare rows. Sits between the tile wrapper's start/done/fail pins and the SRAM macro (or fault-injecting SRAM model).

---
 rtl/mbist_pkg.sv | 46 ++++
 rtl/mbisr_remap_cam.sv | 56 +++++
 rtl/mbist_mbisr_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared types and helpers for the March C- BIST / self-repair controller.
// The element table below is the single source of truth for the test algorithm.
package mbist_pkg;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic has_read;
        logic has_write;
        logic read_bg;
        logic write_bg;
        logic down;
    } elem_info_t;

    // A two-op element always reads first, then writes the opposite background.
    function automatic elem_info_t elem_info(input march_elem_t e);
        elem_info_t info;
        case (e)
            E0:      info = '{has_read: 1'b0, has_write: 1'b1, read_bg: 1'b0, write_bg: 1'b0, down: 1'b0};
            E1:      info = '{has_read: 1'b1, has_write: 1'b1, read_bg: 1'b0, write_bg: 1'b1, down: 1'b0};
            E2:      info = '{has_read: 1'b1, has_write: 1'b1, read_bg: 1'b1, write_bg: 1'b0, down: 1'b0};
            E3:      info = '{has_read: 1'b1, has_write: 1'b1, read_bg: 1'b0, write_bg: 1'b1, down: 1'b1};
            E4:      info = '{has_read: 1'b1, has_write: 1'b1, read_bg: 1'b1, write_bg: 1'b0, down: 1'b1};
            E5:      info = '{has_read: 1'b1, has_write: 1'b0, read_bg: 1'b0, write_bg: 1'b0, down: 1'b0};
            default: info = '0;
        endcase
        return info;
    endfunction

    function automatic logic elem_down(input march_elem_t e);
        elem_info_t info;
        info = elem_info(e);
        return info.down;
    endfunction

    function automatic int cnt_width(input int spares);
        return $clog2(spares + 1);
    endfunction

    function automatic int idx_width(input int spares);
        return (spares > 1) ? $clog2(spares) : 1;
    endfunction

endpackage

// File: rtl/mbisr_remap_cam.sv
// Remap CAM: SPARES entries of faulty addresses, with one search port for the
// BIST compare path and one for functional-mode lookups.
module mbisr_remap_cam
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int SPARES = 4,
    localparam int IDX_W = idx_width(SPARES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ins_en,
    input  logic [IDX_W-1:0]  ins_idx,
    input  logic [ADDR_W-1:0] ins_addr,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              cmp_hit,
    input  logic [ADDR_W-1:0] func_addr,
    output logic              func_hit,
    output logic [IDX_W-1:0]  func_idx
);

    logic [SPARES-1:0] valid;
    logic [ADDR_W-1:0] entry [SPARES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < SPARES; i++) begin
                entry[i] <= '0;
            end
        end else if (clr) begin
            valid <= '0;
        end else if (ins_en) begin
            valid[ins_idx] <= 1'b1;
            entry[ins_idx] <= ins_addr;
        end
    end

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        cmp_hit  = 1'b0;
        func_hit = 1'b0;
        func_idx = '0;
        for (int i = SPARES - 1; i >= 0; i--) begin
            if (valid[i] && entry[i] == cmp_addr) begin
                cmp_hit = 1'b1;
            end
            if (valid[i] && entry[i] == func_addr) begin
                func_hit = 1'b1;
                func_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mbist_mbisr_ctrl.sv
// March C- memory BIST engine with self-repair logging of failing addresses
// into a remap CAM used for functional-mode spare-row steering.
module mbist_mbisr_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int SPARES = 4,
    localparam int CNT_W = cnt_width(SPARES),
    localparam int IDX_W = idx_width(SPARES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              repairable,
    output logic [CNT_W-1:0]  fail_count,
    input  logic [ADDR_W-1:0] func_addr,
    output logic              remap_hit,
    output logic [IDX_W-1:0]  remap_idx
);

    state_t            state, next_state;
    march_elem_t       elem, next_elem;
    elem_info_t        info;
    logic [ADDR_W-1:0] addr;
    logic              opi;
    logic              is_read, last_op, last_addr, start_run;
    logic              rd_pend, rd_bg, mismatch, cmp_hit, ins_en;
    logic [ADDR_W-1:0] rd_addr;

    assign info      = elem_info(elem);
    assign next_elem = march_elem_t'(elem + 3'd1);
    assign is_read   = info.has_read && !opi;
    assign last_op   = !(info.has_read && info.has_write) || opi;
    assign last_addr = info.down ? (addr == '0) : (addr == '1);
    assign start_run = start && (state == IDLE || state == DONE);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign mismatch  = rd_pend && (mem_rdata != {DATA_W{rd_bg}});
    assign ins_en    = mismatch && !cmp_hit && (fail_count < CNT_W'(SPARES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                mem_en    = 1'b1;
                mem_we    = !is_read;
                mem_addr  = addr;
                mem_wdata = {DATA_W{info.write_bg}};
                if (elem == E5 && last_op && last_addr) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Element / address / op sequencer: one memory op per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem <= E0;
            addr <= '0;
            opi  <= 1'b0;
        end else if (start_run) begin
            elem <= E0;
            addr <= '0;
            opi  <= 1'b0;
        end else if (state == RUN) begin
            if (!last_op) begin
                opi <= 1'b1;
            end else begin
                opi <= 1'b0;
                if (!last_addr) begin
                    addr <= info.down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                end else if (elem != E5) begin
                    elem <= next_elem;
                    addr <= elem_down(next_elem) ? '1 : '0;
                end
            end
        end
    end

    // Read data returns a cycle late, so the address and background travel with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            rd_addr    <= '0;
            rd_bg      <= 1'b0;
            fail       <= 1'b0;
            fail_count <= '0;
            repairable <= 1'b1;
        end else begin
            rd_pend <= (state == RUN) && is_read;
            rd_addr <= addr;
            rd_bg   <= info.read_bg;
            if (start_run) begin
                fail       <= 1'b0;
                fail_count <= '0;
                repairable <= 1'b1;
            end else if (mismatch) begin
                fail <= 1'b1;
                if (!cmp_hit) begin
                    if (fail_count < CNT_W'(SPARES)) begin
                        fail_count <= fail_count + CNT_W'(1);
                    end else begin
                        repairable <= 1'b0;
                    end
                end
            end
        end
    end

    mbisr_remap_cam #(
        .ADDR_W (ADDR_W),
        .SPARES (SPARES)
    ) u_cam (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_run),
        .ins_en    (ins_en),
        .ins_idx   (fail_count[IDX_W-1:0]),
        .ins_addr  (rd_addr),
        .cmp_addr  (rd_addr),
        .cmp_hit   (cmp_hit),
        .func_addr (func_addr),
        .func_hit  (remap_hit),
        .func_idx  (remap_idx)
    );

endmodule
